adder_sum_accum: RTL and testbench

Downstream consumer of the 28-bit 2-stage pipelined ripple-carry adder. It takes the 29-bit registered sum stream and accumulates fixed-length blocks of `BLK_LEN` valid sums into an `ACC_W`-bit total. Each finished block total is presented on a valid/ready output register, with a per-block overflow flag and a sticky overrun flag. The upstream controller drives `sum_valid` aligned with the adder's 2-cycle latency.

---
 rtl/adder_sum_accum_if.sv | 52 +++++
 rtl/adder_sum_accum.sv | 130 +++++++++++++
 tb/tb_adder_sum_accum.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/adder_sum_accum_if.sv
// adder_sum_accum_if
// Bundles the sum stream, clear and the block-result valid/ready channel
// of the adder_sum_accum block.
//
// Signals:
//   sum_in     adder sum, SUM_W bits, unsigned
//   sum_valid  sum_in is valid this cycle
//   clr        synchronous clear of the block in progress and overrun
//   acc_out    completed block total, ACC_W bits
//   blk_ovf    overflow occurred in the block now on acc_out
//   acc_valid  acc_out/blk_ovf hold an untaken result
//   acc_ready  consumer accepts the result
//   overrun    sticky: a block completed while the previous result was untaken
//
// Modports:
//   master  upstream controller plus result consumer (drives sums, takes results)
//   slave   the accumulator itself
interface adder_sum_accum_if #(
    parameter int unsigned SUM_W = 29,
    parameter int unsigned ACC_W = 32
);
    logic [SUM_W-1:0] sum_in;
    logic             sum_valid;
    logic             clr;
    logic [ACC_W-1:0] acc_out;
    logic             blk_ovf;
    logic             acc_valid;
    logic             acc_ready;
    logic             overrun;

    modport master (
        output sum_in,
        output sum_valid,
        output clr,
        output acc_ready,
        input  acc_out,
        input  blk_ovf,
        input  acc_valid,
        input  overrun
    );

    modport slave (
        input  sum_in,
        input  sum_valid,
        input  clr,
        input  acc_ready,
        output acc_out,
        output blk_ovf,
        output acc_valid,
        output overrun
    );
endinterface

// File: rtl/adder_sum_accum.sv
// adder_sum_accum
// Accumulates fixed-length blocks of BLK_LEN valid adder sums into an
// ACC_W-bit total. Each finished total is held in a valid/ready output
// register with a per-block overflow flag; a sticky overrun flag records a
// block that completed while the previous result was still untaken (the new
// result is dropped in that case).
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   adder_sum_accum_if.slave (sum stream, clr, result handshake)
//
// Build option:
//   ACC_SATURATE_EN  when defined, an overflowing block total clamps to
//                    all-ones for the rest of the block; otherwise it wraps
//                    modulo 2^ACC_W. blk_ovf is reported in both builds.
module adder_sum_accum #(
    parameter int unsigned SUM_W   = 29,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned BLK_LEN = 16
) (
    input logic              clk,
    input logic              rstn,
    adder_sum_accum_if.slave bus
);
    localparam int unsigned CNT_W   = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam int unsigned EXT_W   = ACC_W + 1 - SUM_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_LEN - 1);

    // Block in progress
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf_run;

    // Output register
    logic [ACC_W-1:0] res_data;
    logic             res_ovf;
    logic             res_valid;
    logic             overrun;

    // Next-state helpers
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum_wide;
    logic             carry;
    logic             ovf_next;
    logic [ACC_W-1:0] acc_next;
    logic             last;
    logic             accept;
    logic             complete;
    logic             take;
    logic             load;

    always_comb begin
        base     = '0;
        sum_wide = '0;
        carry    = 1'b0;
        ovf_next = 1'b0;
        acc_next = '0;
        last     = 1'b0;
        accept   = 1'b0;
        complete = 1'b0;
        take     = 1'b0;
        load     = 1'b0;

        // The first sum of a block starts from zero, so acc need not be
        // cleared when a block completes.
        base     = (cnt == '0) ? '0 : acc;
        sum_wide = {1'b0, base} + {{EXT_W{1'b0}}, bus.sum_in};
        carry    = sum_wide[ACC_W];
        ovf_next = ovf_run | carry;
`ifdef ACC_SATURATE_EN
        // Once the block has overflowed it stays pinned at all-ones.
        acc_next = ovf_next ? '1 : sum_wide[ACC_W-1:0];
`else
        acc_next = sum_wide[ACC_W-1:0];
`endif
        last     = (cnt == CNT_LAST);
        accept   = bus.sum_valid & ~bus.clr;
        complete = accept & last;
        take     = res_valid & bus.acc_ready;
        // A completion may reuse the register on the same edge it is taken.
        load     = complete & (~res_valid | bus.acc_ready);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            acc       <= '0;
            ovf_run   <= 1'b0;
            res_data  <= '0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (bus.clr) begin
                cnt     <= '0;
                acc     <= '0;
                ovf_run <= 1'b0;
                overrun <= 1'b0;
            end else if (accept) begin
                if (last) begin
                    cnt     <= '0;
                    ovf_run <= 1'b0;
                    if (!load) begin
                        overrun <= 1'b1;
                    end
                end else begin
                    acc     <= acc_next;
                    cnt     <= cnt + CNT_W'(1);
                    ovf_run <= ovf_next;
                end
            end

            // The handshake runs independently of clr.
            if (load) begin
                res_data  <= acc_next;
                res_ovf   <= ovf_next;
                res_valid <= 1'b1;
            end else if (take) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign bus.acc_out   = res_data;
    assign bus.blk_ovf   = res_ovf;
    assign bus.acc_valid = res_valid;
    assign bus.overrun   = overrun;

endmodule

// File: tb/tb_adder_sum_accum.sv
// tb_adder_sum_accum
// Directed-vector bench for adder_sum_accum with hand-computed totals.
// Inputs change 1 ns after a rising edge; outputs are checked at the same
// point, i.e. they reflect the edge just taken.
module tb_adder_sum_accum;
    logic clk;
    logic rstn;
    int   total;
    int   bad;

    adder_sum_accum_if #(.SUM_W(29), .ACC_W(32)) bus ();

    adder_sum_accum #(
        .SUM_W  (29),
        .ACC_W  (32),
        .BLK_LEN(16)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [28:0] v);
        bus.sum_in    = v;
        bus.sum_valid = 1'b1;
        step();
        bus.sum_valid = 1'b0;
        bus.sum_in    = '0;
    endtask

    task automatic send_n(input int n, input logic [28:0] v);
        for (int i = 0; i < n; i++) begin
            send(v);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] data, input logic ovf,
                             input logic vld, input logic ovr);
        check_eq({tag, ".acc_out"},   bus.acc_out,   data);
        check_eq({tag, ".blk_ovf"},   32'(bus.blk_ovf),   32'(ovf));
        check_eq({tag, ".acc_valid"}, 32'(bus.acc_valid), 32'(vld));
        check_eq({tag, ".overrun"},   32'(bus.overrun),   32'(ovr));
    endtask

    logic [31:0] ovf_exp;

    initial begin
        total         = 0;
        bad           = 0;
        rstn          = 1'b0;
        bus.sum_in    = '0;
        bus.sum_valid = 1'b0;
        bus.clr       = 1'b0;
        bus.acc_ready = 1'b0;
`ifdef ACC_SATURATE_EN
        ovf_exp = 32'hFFFF_FFFF;
`else
        ovf_exp = 32'hFFFF_FFF0;
`endif

        // Reset state
        #3;
        check_out("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        #9 rstn = 1'b1;
        step();

        // 1..16 with ready high: 136, one-cycle valid pulse
        bus.acc_ready = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            send(29'(i));
        end
        check_eq("seq.pre_valid", 32'(bus.acc_valid), 32'd0);
        send(29'd16);
        check_out("seq.done", 32'd136, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("seq.pulse_end", 32'(bus.acc_valid), 32'd0);

        // Overflow: 16 x 0x1FFFFFFF
        send_n(16, 29'h1FFF_FFFF);
        check_out("ovf.done", ovf_exp, 1'b1, 1'b1, 1'b0);
        step();
        check_eq("ovf.taken", 32'(bus.acc_valid), 32'd0);

        // Next block after an overflowing one starts clean
        send_n(16, 29'd2);
        check_out("ovf.next_clean", 32'd32, 1'b0, 1'b1, 1'b0);
        step();

        // Overrun: two blocks with ready low, first result held
        bus.acc_ready = 1'b0;
        send_n(16, 29'd1);
        check_out("ovr.first", 32'd16, 1'b0, 1'b1, 1'b0);
        send_n(16, 29'd2);
        check_out("ovr.second", 32'd16, 1'b0, 1'b1, 1'b1);
        bus.acc_ready = 1'b1;
        step();
        check_out("ovr.taken", 32'd16, 1'b0, 1'b0, 1'b1);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        check_eq("ovr.clr", 32'(bus.overrun), 32'd0);

        // Completion and take on the same edge
        bus.acc_ready = 1'b0;
        send_n(16, 29'd1);
        check_out("sim.first", 32'd16, 1'b0, 1'b1, 1'b0);
        send_n(15, 29'd3);
        bus.acc_ready = 1'b1;
        send(29'd3);
        check_out("sim.second", 32'd48, 1'b0, 1'b1, 1'b0);
        step();
        check_eq("sim.taken", 32'(bus.acc_valid), 32'd0);

        // Clear mid-block (clr coincides with a valid sum), then gapped block of 3s
        send_n(5, 29'd7);
        bus.clr       = 1'b1;
        bus.sum_valid = 1'b1;
        bus.sum_in    = 29'd100;
        step();
        bus.clr       = 1'b0;
        bus.sum_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if ((i % 3) == 1) step();
            if (i == 15) check_eq("clr.pre_valid", 32'(bus.acc_valid), 32'd0);
            send(29'd3);
        end
        check_out("clr.done", 32'd48, 1'b0, 1'b1, 1'b0);
        step();

        // Async reset mid-block with a held result and overrun pending
        bus.acc_ready = 1'b0;
        send_n(16, 29'd1);
        send_n(16, 29'd2);
        check_out("rst.setup", 32'd16, 1'b0, 1'b1, 1'b1);
        send_n(9, 29'd5);
        rstn = 1'b0;
        #1;
        check_out("rst.async", 32'd0, 1'b0, 1'b0, 1'b0);
        #2 rstn = 1'b1;
        bus.acc_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            send(29'd4);
        end
        check_eq("rst.pre_valid", 32'(bus.acc_valid), 32'd0);
        send(29'd4);
        check_out("rst.fresh", 32'd64, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
